// File: rtl/sw_debounce_if.sv
// Switch front-end bundle: raw pins in, debounced level and change pulses out.
// The debouncer uses the slave modport; whatever drives the pins and reads the results uses master.
interface sw_debounce_if #(
  parameter int unsigned N = 10
);
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_stable;
  logic [N-1:0] sw_changed;
  logic         any_change;

  modport master (
    output sw_raw,
    input  sw_stable,
    input  sw_changed,
    input  any_change
  );

  modport slave (
    input  sw_raw,
    output sw_stable,
    output sw_changed,
    output any_change
  );
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-switch saturating debounce counter for the board slide switches.
// SW_DEBOUNCE_PULSE_EN builds the sw_changed/any_change pulse registers; otherwise those outputs are tied to 0.
module sw_debounce #(
  parameter int unsigned N             = 10,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = 16
) (
  input logic           clk,
  input logic           reset,
  sw_debounce_if.slave  bus
);

  if (STABLE_CYCLES < 1 || (64'd1 << CNT_W) < 64'(STABLE_CYCLES)) begin : g_bad_param
    $error("sw_debounce: STABLE_CYCLES must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [N-1:0]     s1_q, s2_q;
  logic [N-1:0]     stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  // Any cycle of agreement clears the counter, so short glitches never accumulate.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= bus.sw_raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.sw_stable = stable_q;

`ifdef SW_DEBOUNCE_PULSE_EN
  logic [N-1:0] changed_q, changed_d;
  logic         any_q;

  // A bit pulses exactly when its published value is about to flip.
  always_comb begin
    changed_d = stable_d ^ stable_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      changed_q <= '0;
      any_q     <= 1'b0;
    end else begin
      changed_q <= changed_d;
      any_q     <= |changed_d;
    end
  end

  assign bus.sw_changed = changed_q;
  assign bus.any_change = any_q;
`else
  assign bus.sw_changed = '0;
  assign bus.any_change = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with N=10, STABLE_CYCLES=4; pulse expectations follow SW_DEBOUNCE_PULSE_EN.
module tb_sw_debounce;

`ifdef SW_DEBOUNCE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  sw_debounce_if #(.N(10)) bus ();

  sw_debounce #(
    .N             (10),
    .STABLE_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance past one active edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.sw_raw = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] es, ec;
    logic       ea;
    bus.sw_raw = 10'h3FF;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.sw_stable !== 10'h000 || bus.sw_changed !== 10'h000 || bus.any_change !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d stable=%h changed=%h any=%b required 000/000/0",
                 c, bus.sw_stable, bus.sw_changed, bus.any_change);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      es = (e >= 6) ? 10'h3FF : 10'h000;
      ec = (PULSE_EN && e == 6) ? 10'h3FF : 10'h000;
      ea = PULSE_EN && e == 6;
      checks++;
      if (bus.sw_stable !== es || bus.sw_changed !== ec || bus.any_change !== ea) begin
        failures++;
        $display("FAIL reset_release edge=%0d stable=%h changed=%h any=%b required %h/%h/%b",
                 e, bus.sw_stable, bus.sw_changed, bus.any_change, es, ec, ea);
      end
    end
  endtask

  task automatic test_single_press();
    logic [9:0] es, ec;
    logic       ea;
    apply_reset();
    bus.sw_raw = 10'h001;
    for (int e = 0; e <= 8; e++) begin
      tick();
      es = (e >= 5) ? 10'h001 : 10'h000;
      ec = (PULSE_EN && e == 5) ? 10'h001 : 10'h000;
      ea = PULSE_EN && e == 5;
      checks++;
      if (bus.sw_stable !== es || bus.sw_changed !== ec || bus.any_change !== ea) begin
        failures++;
        $display("FAIL single_press edge=%0d stable=%h changed=%h any=%b required %h/%h/%b",
                 e, bus.sw_stable, bus.sw_changed, bus.any_change, es, ec, ea);
      end
    end
  endtask

  task automatic test_glitch();
    logic [9:0] pat [$];
    apply_reset();
    for (int c = 0; c < 3; c++) pat.push_back(10'h008);
    for (int c = 0; c < 5; c++) pat.push_back(10'h000);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 3; c++) pat.push_back(10'h008);
      pat.push_back(10'h000);
    end
    for (int c = 0; c < 5; c++) pat.push_back(10'h000);
    foreach (pat[c]) begin
      bus.sw_raw = pat[c];
      tick();
      checks++;
      if (bus.sw_stable !== 10'h000 || bus.sw_changed !== 10'h000 || bus.any_change !== 1'b0) begin
        failures++;
        $display("FAIL glitch cyc=%0d stable=%h changed=%h any=%b required 000/000/0",
                 c, bus.sw_stable, bus.sw_changed, bus.any_change);
      end
    end
  endtask

  task automatic test_independent_bits();
    logic [9:0] es, ec;
    logic       ea;
    apply_reset();
    // Bit 5 drops for the edge-2 sample only; bit 0 is steady.
    for (int e = 0; e <= 10; e++) begin
      bus.sw_raw = (e == 2) ? 10'h001 : 10'h021;
      tick();
      es = (e >= 8) ? 10'h021 : (e >= 5) ? 10'h001 : 10'h000;
      ec = !PULSE_EN ? 10'h000 : (e == 5) ? 10'h001 : (e == 8) ? 10'h020 : 10'h000;
      ea = PULSE_EN && (e == 5 || e == 8);
      checks++;
      if (bus.sw_stable !== es || bus.sw_changed !== ec || bus.any_change !== ea) begin
        failures++;
        $display("FAIL independent edge=%0d stable=%h changed=%h any=%b required %h/%h/%b",
                 e, bus.sw_stable, bus.sw_changed, bus.any_change, es, ec, ea);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [9:0] es, ec;
    logic       ea;
    apply_reset();
    bus.sw_raw = 10'h200;
    for (int e = 0; e <= 11; e++) begin
      reset = (e == 3);
      tick();
      es = (e >= 9) ? 10'h200 : 10'h000;
      ec = (PULSE_EN && e == 9) ? 10'h200 : 10'h000;
      ea = PULSE_EN && e == 9;
      checks++;
      if (bus.sw_stable !== es || bus.sw_changed !== ec || bus.any_change !== ea) begin
        failures++;
        $display("FAIL reset_mid_count edge=%0d stable=%h changed=%h any=%b required %h/%h/%b",
                 e, bus.sw_stable, bus.sw_changed, bus.any_change, es, ec, ea);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_release();
    logic [9:0] es, ec;
    logic       ea;
    // Falling edge of an accepted switch takes the same latency as a press.
    bus.sw_raw = 10'h000;
    for (int e = 0; e <= 7; e++) begin
      tick();
      es = (e >= 5) ? 10'h000 : 10'h200;
      ec = (PULSE_EN && e == 5) ? 10'h200 : 10'h000;
      ea = PULSE_EN && e == 5;
      checks++;
      if (bus.sw_stable !== es || bus.sw_changed !== ec || bus.any_change !== ea) begin
        failures++;
        $display("FAIL release edge=%0d stable=%h changed=%h any=%b required %h/%h/%b",
                 e, bus.sw_stable, bus.sw_changed, bus.any_change, es, ec, ea);
      end
    end
  endtask

  initial begin
    bus.sw_raw = '0;
    #2;
    test_reset();
    test_single_press();
    test_glitch();
    test_independent_bits();
    test_reset_mid_count();
    test_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
